// File: rtl/reg_hex_display_pkg.sv
// Shared constants for board-level seven-segment display blocks.
// Segment codes are active-low, bit 0 = segment a through bit 6 = segment g.
package reg_hex_display_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [7:0] ANODE_OFF = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;  // lowercase b
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;  // lowercase d
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    // Within a slot the display is either blanked (guard) or driving a digit.
    typedef enum logic {
        PhaseGuard,
        PhaseDrive
    } slot_phase_e;

    function automatic logic [7:0] anode_select(input logic [2:0] digit);
        return ~(8'd1 << digit);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit hex nibble to active-low seven-segment decoder.
module hex7seg
    import reg_hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/reg_hex_display.sv
// Eight-digit scanned hex display driver with frame-stable shadow word,
// per-slot blanking guard and optional leading-zero suppression.
module reg_hex_display
    import reg_hex_display_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned GUARD_CYCLES = 1000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Value,
    input  logic        BlankLZ,
    output logic [7:0]  Anode,
    output logic [6:0]  Cathode,
    output logic        FrameDone
);

    localparam int unsigned CNT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
    localparam logic [2:0] DIGIT_LAST = 3'(NUM_DIGITS - 1);

    if (DIGIT_CYCLES < 2 || GUARD_CYCLES < 1 || GUARD_CYCLES >= DIGIT_CYCLES) begin : g_bad_params
        $error("reg_hex_display: need DIGIT_CYCLES >= 2 and 1 <= GUARD_CYCLES < DIGIT_CYCLES");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_q, digit_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [7:0]       anode_d;
    logic [6:0]       cathode_d;
    logic             frame_done_d;

    logic             slot_end;
    logic             frame_wrap;
    logic             lz_blank;
    logic [3:0]       nibble;
    logic [6:0]       seg;
    slot_phase_e      phase;

    always_comb begin
        slot_end     = (cnt_q == CNT_LAST);
        frame_wrap   = slot_end && (digit_q == DIGIT_LAST);
        cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
        digit_d      = slot_end ? digit_q + 3'd1 : digit_q;
        shadow_d     = frame_wrap ? Value : shadow_q;
        frame_done_d = frame_wrap;
    end

    // Outputs are computed from next-state so the pins match (digit, cnt) after each edge.
    always_comb begin
        nibble   = shadow_d[{digit_d, 2'b00} +: 4];
        lz_blank = BlankLZ && (digit_d != 3'd0) && ((shadow_d >> {digit_d, 2'b00}) == 32'd0);
        phase    = ((cnt_d < CNT_GUARD) || lz_blank) ? PhaseGuard : PhaseDrive;
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg)
    );

    always_comb begin
        anode_d   = ANODE_OFF;
        cathode_d = SEG_BLANK;
        if (phase == PhaseDrive) begin
            anode_d   = anode_select(digit_d);
            cathode_d = seg;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q     <= '0;
            digit_q   <= '0;
            shadow_q  <= '0;
            Anode     <= ANODE_OFF;
            Cathode   <= SEG_BLANK;
            FrameDone <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            shadow_q  <= shadow_d;
            Anode     <= anode_d;
            Cathode   <= cathode_d;
            FrameDone <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_reg_hex_display.sv
// Self-checking bench for reg_hex_display: fixed vectors, corner sequences and
// randomized traffic against an edge-count based reference model.
module tb_reg_hex_display;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Value;
    logic        BlankLZ;
    logic [7:0]  a1, a2;
    logic [6:0]  c1, c2;
    logic        f1, f2;

    int unsigned n;
    logic [31:0] sh1, sh2;
    int unsigned total_cnt = 0;
    int unsigned pass_cnt = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 Clock = ~Clock;

    reg_hex_display #(.DIGIT_CYCLES(8), .GUARD_CYCLES(2)) u_dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Value     (Value),
        .BlankLZ   (BlankLZ),
        .Anode     (a1),
        .Cathode   (c1),
        .FrameDone (f1)
    );

    reg_hex_display #(.DIGIT_CYCLES(5), .GUARD_CYCLES(1)) u_dut_odd (
        .Clock     (Clock),
        .Reset     (Reset),
        .Value     (Value),
        .BlankLZ   (BlankLZ),
        .Anode     (a2),
        .Cathode   (c2),
        .FrameDone (f2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s edge=%0d actual=%0h required=%0h", name, n, act, exp);
    endtask

    // Expected pins after edge n for a display with the given slot timing.
    function automatic void model(input int unsigned en, input int unsigned dc,
                                  input int unsigned gc, input logic [31:0] sh,
                                  input logic blz, output logic [7:0] an,
                                  output logic [6:0] ca, output logic fd);
        int unsigned c;
        int unsigned d;
        logic [3:0]  nib;
        logic        blank;
        c     = en % dc;
        d     = (en / dc) % 8;
        nib   = 4'((sh >> (4 * d)) & 32'hF);
        blank = blz && (d > 0) && ((sh >> (4 * d)) == 32'd0);
        fd    = (en > 0) && (en % (8 * dc) == 0);
        if (c < gc || blank) begin
            an = 8'hFF;
            ca = 7'h7F;
        end else begin
            an = ~(8'd1 << d);
            ca = seg_tab[nib];
        end
    endfunction

    task automatic step_check();
        logic [7:0] ea;
        logic [6:0] ec;
        logic       ef;
        @(posedge Clock);
        n++;
        if (n % 64 == 0) sh1 = Value;
        if (n % 40 == 0) sh2 = Value;
        #1;
        model(n, 8, 2, sh1, BlankLZ, ea, ec, ef);
        chk("anode8", a1, ea);
        chk("cathode8", c1, ec);
        chk("framedone8", f1, ef);
        model(n, 5, 1, sh2, BlankLZ, ea, ec, ef);
        chk("anode5", a2, ea);
        chk("cathode5", c2, ec);
        chk("framedone5", f2, ef);
    endtask

    task automatic run_to(input int unsigned target);
        while (n < target) step_check();
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_anode", a1, 8'hFF);
        chk("rst_cathode", c1, 7'h7F);
        chk("rst_framedone", f1, 1'b0);
        chk("rst_anode5", a2, 8'hFF);
        @(negedge Clock);
        Reset = 1'b1;
        n   = 0;
        sh1 = '0;
        sh2 = '0;
    endtask

    typedef struct {
        int unsigned at;
        logic [7:0]  an;
        logic [6:0]  ca;
        logic        fd;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1,   8'hFF, 7'h7F, 1'b0};
        vecs[1]  = '{2,   8'hFE, 7'h40, 1'b0};
        vecs[2]  = '{7,   8'hFE, 7'h40, 1'b0};
        vecs[3]  = '{8,   8'hFF, 7'h7F, 1'b0};
        vecs[4]  = '{10,  8'hFD, 7'h40, 1'b0};
        vecs[5]  = '{64,  8'hFF, 7'h7F, 1'b1};
        vecs[6]  = '{65,  8'hFF, 7'h7F, 1'b0};
        vecs[7]  = '{66,  8'hFE, 7'h21, 1'b0};
        vecs[8]  = '{71,  8'hFE, 7'h21, 1'b0};
        vecs[9]  = '{74,  8'hFD, 7'h46, 1'b0};
        vecs[10] = '{98,  8'hEF, 7'h19, 1'b0};
        vecs[11] = '{122, 8'h7F, 7'h79, 1'b0};
        vecs[12] = '{127, 8'h7F, 7'h79, 1'b0};
        vecs[13] = '{128, 8'hFF, 7'h7F, 1'b1};

        n       = 0;
        sh1     = '0;
        sh2     = '0;
        Value   = 32'h1234ABCD;
        BlankLZ = 1'b0;
        do_reset();

        // First frame shows the reset shadow, second frame the loaded word.
        for (int i = 0; i < 14; i++) begin
            run_to(vecs[i].at);
            chk("vec_anode", a1, vecs[i].an);
            chk("vec_cathode", c1, vecs[i].ca);
            chk("vec_framedone", f1, vecs[i].fd);
        end

        // Asynchronous reset in the middle of a drive phase.
        run_to(132);
        chk("pre_rst_anode", a1, 8'hFE);
        #2 Reset = 1'b0;
        #1;
        chk("async_anode", a1, 8'hFF);
        chk("async_cathode", c1, 7'h7F);
        chk("async_framedone", f1, 1'b0);
        do_reset();

        // Leading-zero blanking.
        Value   = 32'h000000A5;
        BlankLZ = 1'b1;
        run_to(66);
        chk("lz_d0_anode", a1, 8'hFE);
        chk("lz_d0_cathode", c1, 7'h12);
        run_to(74);
        chk("lz_d1_anode", a1, 8'hFD);
        chk("lz_d1_cathode", c1, 7'h08);
        run_to(82);
        chk("lz_d2_anode", a1, 8'hFF);
        run_to(127);
        chk("lz_d7_anode", a1, 8'hFF);
        Value = 32'h0;
        run_to(130);
        chk("lz_zero_d0_anode", a1, 8'hFE);
        chk("lz_zero_d0_cathode", c1, 7'h40);
        run_to(138);
        chk("lz_zero_d1_anode", a1, 8'hFF);
        do_reset();

        // Mid-frame change of Value is deferred to the next frame wrap.
        Value   = 32'h11111111;
        BlankLZ = 1'b0;
        run_to(80);
        Value = 32'h22222222;
        run_to(90);
        chk("hold_cathode", c1, 7'h79);
        run_to(122);
        chk("hold_late_cathode", c1, 7'h79);
        run_to(130);
        chk("next_frame_cathode", c1, 7'h24);
        do_reset();

        // Randomized traffic across many frames of both instances.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 15) == 0) Value = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 31) == 0) BlankLZ = ~BlankLZ;
            step_check();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg_hex_display.md
# reg_hex_display

Scanned eight-digit hexadecimal seven-segment driver that consumes the 32-bit `out_Reg23` word produced by the processor datapath top and shows it on the board's multiplexed common-anode display. It holds a frame-stable shadow copy of the word, time-multiplexes the eight digits with a blanking guard interval to suppress ghosting, and optionally blanks leading zeros. It sits directly downstream of the datapath top, at board-top level.

## Interface
Parameters:
- `DIGIT_CYCLES`, 100000: clock cycles per digit slot. Legal range is 2 or more.
- `GUARD_CYCLES`, 1000: blanked cycles at the start of each slot. Legal range is 1 ≤ GUARD_CYCLES < DIGIT_CYCLES.

Ports:
- `Clock`  in  1: the only clock; all flops are rising-edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `Value`  in  32: word to display (from `out_Reg23`). It is sampled only at frame boundaries.
- `BlankLZ`  in  1: 1 enables leading-zero blanking.
- `Anode`  out  8: digit enables, active-low. Bit i drives digit i; digit 0 is the least-significant nibble.
- `Cathode`  out  7: segments, active-low. Bit 0 is a through bit 6 is g.
- `FrameDone`  out  1: one-cycle pulse when a new frame (new shadow value) starts.

## Operation
- State consists of:
  - slot counter `cnt` (0..DIGIT_CYCLES-1),
  - digit index `digit` (3 bits, 0..7),
  - 32-bit `shadow`,
  - registered outputs.
- Each edge increments `cnt`. On the edge where cnt == DIGIT_CYCLES-1, `cnt` goes to 0 and `digit` increments, wrapping from 7 to 0.
- Frame wrap is the edge where cnt == DIGIT_CYCLES-1 and digit == 7. On that edge:
  - `shadow` loads `Value`;
  - `FrameDone` is 1 for the following cycle only.
  
  `Value` changes at any other time have no visible effect until the next frame wrap.
- The slot has two phases:
  - GUARD (cnt < GUARD_CYCLES): Anode = 8'hFF and Cathode = 7'h7F.
  - DRIVE (cnt ≥ GUARD_CYCLES): Anode = ~(1 << digit) and Cathode = hex7seg(shadow[4*digit +: 4]).
- Leading-zero blanking applies when BlankLZ == 1, digit > 0, and shadow[31:4*digit] == 0. In that case DRIVE behaves like GUARD for the slot. Digit 0 is never blanked.
- Segment codes (g..a, active-low), hex 0–F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E. Letters b and d are lowercase.
- Outputs are flops loaded from next-state values, so Anode and Cathode always correspond to the current (digit, cnt) with no combinational path to the pins.

## Timing
- Reset values, applied while Reset == 0 and asynchronously on assertion:
  - cnt = 0, digit = 0, shadow = 0;
  - Anode = 8'hFF, Cathode = 7'h7F, FrameDone = 0.
- Reset asserted mid-slot or mid-frame blanks the display immediately. After release, scanning restarts at digit 0, cnt 0, and the first frame displays 0.
- Number edges n = 1, 2, … after reset release. After edge n:
  - cnt = n mod DIGIT_CYCLES;
  - digit = (n / DIGIT_CYCLES) mod 8.
- Frame period is 8·DIGIT_CYCLES cycles. FrameDone is high after edges k·8·DIGIT_CYCLES (k ≥ 1) and low after every other edge.
- `BlankLZ` is sampled combinationally into the next-state logic every edge; there is no frame hold on it.

## Structure
- The segment code constants and the NUM_DIGITS = 8 constant go in a shared include file, available for reuse by future board-level display blocks.
- Sub-module `hex7seg` is a purely combinational 4-bit-to-7-segment decoder. It is instantiated once, fed the currently selected nibble.
- Counter, digit index, shadow and output registers live in `reg_hex_display`. The GUARD/DRIVE phase is derived from `cnt`; there is no separate state register.

## Test plan
All scenarios use DIGIT_CYCLES = 8 and GUARD_CYCLES = 2 unless noted.
- **Reset:** hold Reset = 0 for 3 cycles → Anode = FF, Cathode = 7F, FrameDone = 0. Assert Reset mid-DRIVE → the same values appear immediately, without waiting for a clock edge.
- **First frame and shadow load:** Value = 32'h1234ABCD, BlankLZ = 0 from release.
  - After edges 2–7: Anode = FE, Cathode = 40 (shadow still 0).
  - After edge 64: FrameDone = 1; after edge 65: FrameDone = 0.
  - After edges 66–71: Anode = FE, Cathode = 21 (D).
  - After edges 122–127: Anode = 7F, Cathode = 79 (1).
- **Guard:** across all frames, after every edge with cnt ∈ {0, 1}, Anode = FF and Cathode = 7F.
- **Leading-zero blanking:** Value = 32'h000000A5, BlankLZ = 1, second frame.
  - Digit 0 shows 12 (5); digit 1 shows 08 (A).
  - Digits 2–7: Anode = FF for the whole slot.
  - Value = 0: only digit 0 is driven, showing 40.
- **Mid-frame change:** Value goes from 32'h11111111 to 32'h22222222 at edge 80 → frame 2 (edges 64–127) shows only 79. Frame 3, starting at edge 128, shows only 24.
- **Wrap with large parameter:** DIGIT_CYCLES = 100000, GUARD_CYCLES = 1000 → FrameDone period is exactly 800000 cycles, and the digit index sequence is 0..7,0 with no skipped or repeated slot.
